button_event_fifo: RTL and testbench

- Sits directly downstream of the button/switch debouncer and consumes its NIN-bit debounced vector.
- Detects every change in that vector and records it as an event word: {timestamp, new vector value}.
- Buffers events in a first-word-fall-through FIFO, read by the CPU-side peripheral wrapper with a valid/read handshake.
- Flags lost events and raises an interrupt whenever events are pending.

---
 rtl/button_event_fifo.sv | 101 ++++++++++
 tb/tb_button_event_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fifo.sv
// Change detector and timestamped FWFT event queue for debounced inputs.
// Tracks dropped events and raises an interrupt while events are pending.
module button_event_fifo #(
  parameter int NIN    = 21,
  parameter int TSW    = 11,
  parameter int LGFIFO = 4,
  parameter int LGDROP = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [NIN-1:0]      i_debounced,
  input  logic                i_rd,
  output logic                o_valid,
  output logic [TSW+NIN-1:0]  o_data,
  output logic [LGFIFO:0]     o_fill,
  output logic                o_overflow,
  output logic [LGDROP-1:0]   o_drops,
  input  logic                i_clr_ovf,
  output logic                o_int
);

  localparam int DW    = TSW + NIN;
  localparam int DEPTH = 1 << LGFIFO;

  localparam logic [LGFIFO:0]   P_ONE = 1;
  localparam logic [TSW-1:0]    T_ONE = 1;
  localparam logic [LGDROP-1:0] D_ONE = 1;

  logic [DW-1:0]      mem [DEPTH];

  logic [NIN-1:0]     prev_q;
  logic [TSW-1:0]     ts_q,    ts_d;
  logic [LGFIFO:0]    wr_q,    wr_d;
  logic [LGFIFO:0]    rd_q,    rd_d;
  logic [LGFIFO:0]    fill_q,  fill_d;
  logic               ovf_q,   ovf_d;
  logic [LGDROP-1:0]  drops_q, drops_d;

  logic chg, pop, full, push, drop;

  // Event detection, handshake decode and next-state computation
  always_comb begin
    chg     = (i_debounced != prev_q);
    pop     = i_rd & (fill_q != '0);
    full    = fill_q[LGFIFO];
    push    = chg & (~full | pop);
    drop    = chg & full & ~pop;
    ts_d    = ts_q + T_ONE;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (push) wr_d = wr_q + P_ONE;
    if (pop)  rd_d = rd_q + P_ONE;
    if (push & ~pop)      fill_d = fill_q + P_ONE;
    else if (pop & ~push) fill_d = fill_q - P_ONE;
    if (drop) begin
      ovf_d = 1'b1;
      if (i_clr_ovf)      drops_d = D_ONE;
      else if (~&drops_q) drops_d = drops_q + D_ONE;
    end else if (i_clr_ovf) begin
      ovf_d   = 1'b0;
      drops_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_q  <= '0;
      ts_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      prev_q  <= i_debounced;
      ts_q    <= ts_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  // Event storage; contents are left unreset on purpose
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_q[LGFIFO-1:0]] <= {ts_q, i_debounced};
  end

  assign o_data     = mem[rd_q[LGFIFO-1:0]];
  assign o_valid    = (fill_q != '0);
  assign o_fill     = fill_q;
  assign o_overflow = ovf_q;
  assign o_drops    = drops_q;
  assign o_int      = o_valid;

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed bench for button_event_fifo.
// Expected values are hand-derived from the edge count since reset.
module tb_button_event_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] din = '0;
  logic        rd = 1'b0;
  logic        clr = 1'b0;
  logic        valid;
  logic [31:0] data;
  logic [4:0]  fill;
  logic        ovf;
  logic [7:0]  drops;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int edges = 0;
  int t0;

  button_event_fifo dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_debounced (din),
    .i_rd        (rd),
    .o_valid     (valid),
    .o_data      (data),
    .o_fill      (fill),
    .o_overflow  (ovf),
    .o_drops     (drops),
    .i_clr_ovf   (clr),
    .o_int       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  function automatic logic [31:0] ev(input int ts, input int v);
    logic [10:0] t;
    logic [20:0] x;
    t = ts[10:0];
    x = v[20:0];
    return {t, x};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_int", irq, 0);
    rst_n = 1'b1;
    edges = 0;

    // 1: idle, empty read ignored, then step at timestamp 25
    repeat (20) tick();
    chk("t1_valid", valid, 0);
    chk("t1_fill", fill, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t1_underflow", fill, 0);
    repeat (4) tick();
    din = 21'h1;
    tick();
    chk("t1_valid1", valid, 1);
    chk("t1_int1", irq, 1);
    chk("t1_data", data, ev(25, 1));
    chk("t1_fill1", fill, 1);

    // cleanup so the vector baseline is zero
    rd = 1'b1;
    tick();
    rd = 1'b0;
    din = '0;
    tick();
    chk("t2_pre", data, ev(edges - 1, 0));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t2_empty", fill, 0);

    // 2: toggle bit 3 on four consecutive clocks
    din = 21'h8;
    tick();
    t0 = edges - 1;
    din = 21'h0;
    tick();
    din = 21'h8;
    tick();
    din = 21'h0;
    tick();
    chk("t2_fill", fill, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop", data, ev(t0 + i, (i % 2 == 0) ? 8 : 0));
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    chk("t2_drained", fill, 0);

    // 3: fill to 16, then three drops
    for (int k = 0; k < 16; k++) begin
      din = 21'(k + 1);
      tick();
      if (k == 0) t0 = edges - 1;
    end
    chk("t3_full", fill, 16);
    chk("t3_noovf", ovf, 0);
    for (int k = 0; k < 3; k++) begin
      din = 21'(100 + k);
      tick();
    end
    chk("t3_fill", fill, 16);
    chk("t3_ovf", ovf, 1);
    chk("t3_drops", drops, 3);
    chk("t3_head", data, ev(t0, 1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_ovf", ovf, 0);
    chk("t3_clr_drops", drops, 0);

    // 4: push and pop on the same edge while full
    din = 21'd200;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    t0 = edges - 1;
    chk("t4_fill", fill, 16);
    chk("t4_drops", drops, 0);
    chk("t4_ovf", ovf, 0);
    chk("t4_head", data[20:0], 2);
    for (int i = 0; i < 15; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    chk("t4_last", data, ev(t0, 200));
    chk("t4_fill1", fill, 1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t4_empty", fill, 0);

    // 5: saturate the drop counter, then drop beats clear
    for (int k = 0; k < 16; k++) begin
      din = 21'(1000 + k);
      tick();
    end
    for (int k = 0; k < 300; k++) begin
      din = 21'(2000 + k);
      tick();
    end
    chk("t5_sat", drops, 8'hFF);
    chk("t5_ovf", ovf, 1);
    din = 21'd5000;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_drop", drops, 1);
    chk("t5_clr_ovf", ovf, 1);
    chk("t5_fill", fill, 16);

    // 6: async reset with five entries stored
    rd = 1'b1;
    repeat (11) tick();
    rd = 1'b0;
    chk("t6_fill5", fill, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_fill", fill, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_drops", drops, 0);
    chk("t6_int", irq, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    tick();
    chk("t6_evfill", fill, 1);
    chk("t6_evdata", data, ev(0, 5000));
    tick();
    tick();
    chk("t6_once", fill, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
